// File: rtl/uart_pkg.sv
// Shared definitions for the uart_serial_link transceiver.
//   tx_state_t / rx_state_t : FSM encodings. IDLE is zero, so "state != 0" means busy.
//   LINE_IDLE / START_BIT / STOP_BIT : serial line levels.
//   idx_width()   : width of a bit index over a BIT_LEN-bit word (at least 1).
//   even_parity() : XOR of all data bits (words up to 32 bits).
// Optional feature macro: UART_PARITY_EN (the PARITY states are used only when it is defined).
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int idx_width(input int n);
    idx_width = (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic even_parity(input logic [31:0] word);
    even_parity = ^word;
  endfunction

endpackage

// File: rtl/uart_serial_link_if.sv
// Parallel-side interface of one uart_serial_link endpoint.
//   tx_start, tx_data_in       : send request and word (user -> link)
//   rx_data_out, rx_out_vaild  : last good received word and its valid flag (link -> user)
//   tx_state, tx_send_idx      : transmitter FSM state and current data-bit index (status)
//   rx_state, rx_fetch_idx     : receiver FSM state and current data-bit index (status)
// Modports: master = user side, slave = the transceiver.
interface uart_serial_link_if #(parameter int BIT_LEN = 7);
  localparam int IDX_W = uart_pkg::idx_width(BIT_LEN);

  logic                 tx_start;
  logic [BIT_LEN-1:0]   tx_data_in;
  logic [BIT_LEN-1:0]   rx_data_out;
  logic                 rx_out_vaild;
  uart_pkg::tx_state_t  tx_state;
  logic [IDX_W-1:0]     tx_send_idx;
  uart_pkg::rx_state_t  rx_state;
  logic [IDX_W-1:0]     rx_fetch_idx;

  modport master (
    output tx_start, tx_data_in,
    input  rx_data_out, rx_out_vaild, tx_state, tx_send_idx, rx_state, rx_fetch_idx
  );

  modport slave (
    input  tx_start, tx_data_in,
    output rx_data_out, rx_out_vaild, tx_state, tx_send_idx, rx_state, rx_fetch_idx
  );
endinterface

// File: rtl/uart_serial_rx.sv
// Serial-to-parallel receiver, one sample per clock (link partners share the clock).
//   clk, rst   : clock, asynchronous active-high reset
//   line_in    : serial input
//   data_out   : last correctly received word (unchanged by bad frames)
//   is_valid   : high from a good stop bit until the next start bit or reset
//   state      : FSM state (IDLE = 0)
//   fetch_idx  : index of the data bit being sampled
// With UART_PARITY_EN an even-parity bit precedes the stop bit and must match.
module uart_serial_rx import uart_pkg::*; #(
  parameter int BIT_LEN = 7
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              line_in,
  output logic [BIT_LEN-1:0]                data_out,
  output logic                              is_valid,
  output rx_state_t                         state,
  output logic [idx_width(BIT_LEN)-1:0]     fetch_idx
);
  localparam int IDX_W = idx_width(BIT_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BIT_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  rx_state_t          state_r, state_s;
  logic [IDX_W-1:0]   fetch_idx_r, fetch_idx_s;
  logic [BIT_LEN-1:0] word_r, word_s;
  logic [BIT_LEN-1:0] data_out_r, data_out_s;
  logic               valid_r, valid_s;
  logic               frame_ok_s;
`ifdef UART_PARITY_EN
  logic               par_ok_r, par_ok_s;
`endif

  // A frame is accepted only if the stop bit is high (and parity matched when enabled).
  always_comb begin
`ifdef UART_PARITY_EN
    frame_ok_s = (line_in == STOP_BIT) && par_ok_r;
`else
    frame_ok_s = (line_in == STOP_BIT);
`endif
  end

  // Next-state logic for the receive FSM.
  always_comb begin
    state_s     = state_r;
    fetch_idx_s = fetch_idx_r;
    word_s      = word_r;
    data_out_s  = data_out_r;
    valid_s     = valid_r;
`ifdef UART_PARITY_EN
    par_ok_s    = par_ok_r;
`endif
    case (state_r)
      RX_IDLE: begin
        if (line_in == START_BIT) begin
          state_s     = RX_DATA;
          fetch_idx_s = {IDX_W{1'b0}};
          valid_s     = 1'b0;
        end else begin
          state_s = RX_IDLE;
        end
      end
      RX_DATA: begin
        word_s[fetch_idx_r] = line_in;
        if (fetch_idx_r == LAST_IDX) begin
`ifdef UART_PARITY_EN
          state_s = RX_PARITY;
`else
          state_s = RX_STOP;
`endif
        end else begin
          fetch_idx_s = fetch_idx_r + IDX_ONE;
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        // word_r is complete here: the last data bit was stored on the previous edge.
        par_ok_s = (line_in == even_parity(32'(word_r)));
        state_s  = RX_STOP;
      end
`endif
      RX_STOP: begin
        state_s = RX_IDLE;
        if (frame_ok_s) begin
          data_out_s = word_r;
          valid_s    = 1'b1;
        end else begin
          valid_s = 1'b0;
        end
      end
      default: begin
        state_s = RX_IDLE;
      end
    endcase
  end

  // State registers; reset discards any partially assembled word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RX_IDLE;
      fetch_idx_r <= {IDX_W{1'b0}};
      word_r      <= {BIT_LEN{1'b0}};
      data_out_r  <= {BIT_LEN{1'b0}};
      valid_r     <= 1'b0;
`ifdef UART_PARITY_EN
      par_ok_r    <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      fetch_idx_r <= fetch_idx_s;
      word_r      <= word_s;
      data_out_r  <= data_out_s;
      valid_r     <= valid_s;
`ifdef UART_PARITY_EN
      par_ok_r    <= par_ok_s;
`endif
    end
  end

  assign data_out  = data_out_r;
  assign is_valid  = valid_r;
  assign state     = state_r;
  assign fetch_idx = fetch_idx_r;

endmodule

// File: rtl/uart_serial_tx.sv
// Parallel-to-serial transmitter, one bit per clock.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : send request, sampled only in IDLE
//   data_in   : word latched on the accepted request
//   line_out  : registered serial output, idle high
//   state     : FSM state (IDLE = 0)
//   send_idx  : index of the data bit currently on the line
// Frame: start, BIT_LEN data bits LSB first, [even parity if UART_PARITY_EN], stop.
module uart_serial_tx import uart_pkg::*; #(
  parameter int BIT_LEN = 7
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [BIT_LEN-1:0]                data_in,
  output logic                              line_out,
  output tx_state_t                         state,
  output logic [idx_width(BIT_LEN)-1:0]     send_idx
);
  localparam int IDX_W = idx_width(BIT_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BIT_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  tx_state_t          state_r, state_s;
  logic [IDX_W-1:0]   send_idx_r, send_idx_s;
  logic [BIT_LEN-1:0] shift_r, shift_s;
  logic               line_r, line_s;
`ifdef UART_PARITY_EN
  logic               par_r, par_s;
`endif

  // Next-state logic; the line value is computed together with the state it belongs to,
  // so the registered line always matches the registered state.
  always_comb begin
    state_s    = state_r;
    send_idx_s = send_idx_r;
    shift_s    = shift_r;
    line_s     = line_r;
`ifdef UART_PARITY_EN
    par_s      = par_r;
`endif
    case (state_r)
      TX_IDLE: begin
        if (start) begin
          state_s = TX_START;
          shift_s = data_in;
          line_s  = START_BIT;
`ifdef UART_PARITY_EN
          par_s   = even_parity(32'(data_in));
`endif
        end else begin
          line_s = LINE_IDLE;
        end
      end
      TX_START: begin
        state_s    = TX_DATA;
        send_idx_s = {IDX_W{1'b0}};
        line_s     = shift_r[0];
        shift_s    = shift_r >> 1'b1;
      end
      TX_DATA: begin
        if (send_idx_r == LAST_IDX) begin
`ifdef UART_PARITY_EN
          state_s = TX_PARITY;
          line_s  = par_r;
`else
          state_s = TX_STOP;
          line_s  = STOP_BIT;
`endif
        end else begin
          send_idx_s = send_idx_r + IDX_ONE;
          line_s     = shift_r[0];
          shift_s    = shift_r >> 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        state_s = TX_STOP;
        line_s  = STOP_BIT;
      end
`endif
      TX_STOP: begin
        state_s = TX_IDLE;
        line_s  = LINE_IDLE;
      end
      default: begin
        state_s = TX_IDLE;
        line_s  = LINE_IDLE;
      end
    endcase
  end

  // State registers; reset drops the frame and returns the line high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= TX_IDLE;
      send_idx_r <= {IDX_W{1'b0}};
      shift_r    <= {BIT_LEN{1'b0}};
      line_r     <= LINE_IDLE;
`ifdef UART_PARITY_EN
      par_r      <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      send_idx_r <= send_idx_s;
      shift_r    <= shift_s;
      line_r     <= line_s;
`ifdef UART_PARITY_EN
      par_r      <= par_s;
`endif
    end
  end

  assign line_out = line_r;
  assign state    = state_r;
  assign send_idx = send_idx_r;

endmodule

// File: rtl/uart_serial_link.sv
// Full-duplex UART endpoint: one transmitter and one receiver on a shared clock,
// one bit per clock, no baud divider. Two instances are cross-connected to form a link.
//   clk, rst        : clock, asynchronous active-high reset
//   link (slave)    : tx_start/tx_data_in in, rx_data_out/rx_out_vaild out, FSM status out
//   tx_channel_out  : registered serial output, idle high
//   rx_channel_in   : serial input
// Optional feature macro: UART_PARITY_EN (even parity bit between data and stop).
module uart_serial_link import uart_pkg::*; #(
  parameter int BIT_LEN = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_serial_link_if.slave    link,
  output logic                 tx_channel_out,
  input  logic                 rx_channel_in
);

  uart_serial_tx #(.BIT_LEN(BIT_LEN)) tx (
    .clk      (clk),
    .rst      (rst),
    .start    (link.tx_start),
    .data_in  (link.tx_data_in),
    .line_out (tx_channel_out),
    .state    (link.tx_state),
    .send_idx (link.tx_send_idx)
  );

  uart_serial_rx #(.BIT_LEN(BIT_LEN)) rx (
    .clk       (clk),
    .rst       (rst),
    .line_in   (rx_channel_in),
    .data_out  (link.rx_data_out),
    .is_valid  (link.rx_out_vaild),
    .state     (link.rx_state),
    .fetch_idx (link.rx_fetch_idx)
  );

endmodule

// File: tb/tb_uart_serial_link.sv
// Self-checking bench: two cross-connected uart_serial_link endpoints (u0 -> u1 main path).
// Expected words are queued when a frame is launched and popped when u1 raises rx_out_vaild.
module tb_uart_serial_link;
  import uart_pkg::*;

  localparam int BIT_LEN = 7;
`ifdef UART_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME = BIT_LEN + 2 + PAR_BITS;
  localparam int LAT   = FRAME + 1;

  logic clk = 1'b0;
  logic rst;
  logic line01, line10, rx_in1;
  logic inj_en, inj_val;
  int   cmp_cnt = 0;
  int   err_cnt = 0;
  logic [BIT_LEN-1:0] sb_q[$];
  logic [BIT_LEN-1:0] last_good;
  logic [BIT_LEN-1:0] sb_exp;
  logic prev_v1;

  uart_serial_link_if #(.BIT_LEN(BIT_LEN)) if0 ();
  uart_serial_link_if #(.BIT_LEN(BIT_LEN)) if1 ();

  uart_serial_link #(.BIT_LEN(BIT_LEN)) u0 (
    .clk(clk), .rst(rst), .link(if0), .tx_channel_out(line01), .rx_channel_in(line10)
  );
  uart_serial_link #(.BIT_LEN(BIT_LEN)) u1 (
    .clk(clk), .rst(rst), .link(if1), .tx_channel_out(line10), .rx_channel_in(rx_in1)
  );

  // Fault injection point on the u0 -> u1 line.
  assign rx_in1 = inj_en ? inj_val : line01;

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: every rising edge of u1's valid must match the oldest queued word.
  always @(negedge clk) begin
    if (rst) begin
      prev_v1 <= 1'b0;
    end else begin
      if (if1.rx_out_vaild && !prev_v1) begin
        check_val("sb_pending", 32'(sb_q.size() != 0), 32'(1));
        if (sb_q.size() != 0) begin
          sb_exp = sb_q.pop_front();
          check_val("sb_word", 32'(if1.rx_data_out), 32'(sb_exp));
        end
      end
      prev_v1 <= if1.rx_out_vaild;
    end
  end

  // mode 0 = clean frame, 1 = stop bit forced low, 2 = parity bit flipped.
  task automatic send_frame(input logic [BIT_LEN-1:0] d, input int mode,
                            input bit dup, input logic [BIT_LEN-1:0] d1);
    logic exp_line [1:FRAME];
    logic par;
    par = ^d;
    for (int k = 1; k <= FRAME; k++) begin
      if (k == 1)                exp_line[k] = 1'b0;
      else if (k <= BIT_LEN + 1) exp_line[k] = d[k-2];
      else if (k == FRAME)       exp_line[k] = 1'b1;
      else                       exp_line[k] = par;
    end
    @(posedge clk); #1;
    if0.tx_start = 1'b1; if0.tx_data_in = d;
    if1.tx_start = dup;  if1.tx_data_in = d1;
    if (mode == 0) sb_q.push_back(d);
    @(posedge clk); #1;
    if0.tx_start = 1'b0; if0.tx_data_in = ~d;
    if1.tx_start = 1'b0; if1.tx_data_in = ~d1;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      inj_en = 1'b0;
      if (k <= FRAME) check_val("line_bit", 32'(line01), 32'(exp_line[k]));
      if (k == 2) check_val("vld_drop_at_start", 32'(if1.rx_out_vaild), 32'(0));
      if (k == LAT - 1) check_val("vld_not_early", 32'(if1.rx_out_vaild), 32'(0));
      if (mode == 1 && k == FRAME) begin inj_val = 1'b0; inj_en = 1'b1; end
      if (mode == 2 && k == BIT_LEN + 2) begin inj_val = ~par; inj_en = 1'b1; end
      if (k == LAT) begin
        check_val("rx_idle_after", 32'(if1.rx_state), 32'(RX_IDLE));
        check_val("tx_idle_after", 32'(if0.tx_state), 32'(TX_IDLE));
        if (mode == 0) begin
          check_val("rx_vld", 32'(if1.rx_out_vaild), 32'(1));
          check_val("rx_data", 32'(if1.rx_data_out), 32'(d));
          last_good = d;
        end else begin
          check_val("bad_vld", 32'(if1.rx_out_vaild), 32'(0));
          check_val("bad_keep", 32'(if1.rx_data_out), 32'(last_good));
        end
        if (dup) begin
          check_val("dup_vld", 32'(if0.rx_out_vaild), 32'(1));
          check_val("dup_data", 32'(if0.rx_data_out), 32'(d1));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    inj_en = 1'b0; inj_val = 1'b1;
    if0.tx_start = 1'b0; if0.tx_data_in = '0;
    if1.tx_start = 1'b0; if1.tx_data_in = '0;
    last_good = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_line", 32'(line01), 32'(1));
    check_val("rst_data", 32'(if1.rx_data_out), 32'(0));
    check_val("rst_idx", 32'({if0.tx_send_idx, if1.rx_fetch_idx}), 32'(0));
    @(posedge clk); #1 rst = 1'b0;

    // Idle line: nothing may move.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_val("idle", 32'({line01, line10, if0.rx_out_vaild, if1.rx_out_vaild,
                             if0.tx_state != TX_IDLE, if1.rx_state != RX_IDLE}), 32'(6'b110000));
    end

    // 0x55 u0->u1 with a simultaneous 0x2C u1->u0.
    send_frame(7'h55, 0, 1'b1, 7'h2C);
    // Back-to-back words.
    send_frame(7'h7F, 0, 1'b0, 7'h00);
    send_frame(7'h00, 0, 1'b0, 7'h00);
    send_frame(7'h2A, 0, 1'b0, 7'h00);
    // Stop bit forced low: word dropped, previous data kept.
    send_frame(7'h12, 1, 1'b0, 7'h00);

    // Reset in the middle of DATA (send_idx = 3).
    @(posedge clk); #1;
    if0.tx_start = 1'b1; if0.tx_data_in = 7'h44;
    @(posedge clk); #1;
    if0.tx_start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_val("mid_send_idx", 32'(if0.tx_send_idx), 32'(3));
    check_val("mid_tx_state", 32'(if0.tx_state), 32'(TX_DATA));
    rst = 1'b1;
    #1;
    check_val("arst_line", 32'(line01), 32'(1));
    check_val("arst_tx_idle", 32'(if0.tx_state), 32'(TX_IDLE));
    check_val("arst_rx_idle", 32'(if1.rx_state), 32'(RX_IDLE));
    check_val("arst_vld", 32'(if1.rx_out_vaild), 32'(0));
    check_val("arst_data", 32'(if1.rx_data_out), 32'(0));
    last_good = '0;
    @(posedge clk); #1 rst = 1'b0;
    send_frame(7'h33, 0, 1'b0, 7'h00);

`ifdef UART_PARITY_EN
    send_frame(7'h07, 0, 1'b0, 7'h00);
    send_frame(7'h07, 2, 1'b0, 7'h00);
`endif

    repeat (3) @(negedge clk);
    check_val("sb_drain", 32'(sb_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/uart_serial_link.md
Name: uart_serial_link

Overview:
- Full-duplex UART transceiver with one transmitter and one receiver sharing a clock.
- The serial channel runs at one bit per clock cycle. There is no baud divider or oversampling, because link partners share the clock.
- Two instances are cross-connected, each one's tx_channel_out driving the other's rx_channel_in, to form a point-to-point link.
- Sub-units: tx (parallel-to-serial) and rx (serial-to-parallel).

Parameters:
- BIT_LEN, default 7: data bits per frame, minimum 1.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- tx_start, input, 1: request to send tx_data_in; sampled only while tx is IDLE.
- tx_data_in, input, BIT_LEN: word to transmit.
- tx_channel_out, output, 1: serial line out; idle high; registered.
- rx_channel_in, input, 1: serial line in.
- rx_data_out, output, BIT_LEN: last correctly received word.
- rx_out_vaild, output, 1: received-word valid flag. The spelling "vaild" is the fixed port name.

Behaviour:
- Frame format: start bit (0), then BIT_LEN data bits LSB first, then [parity bit when PARITY_EN], then stop bit (1). One bit per clk cycle.
- Reset values: tx_channel_out=1, rx_data_out=0, rx_out_vaild=0, both FSMs IDLE, send_idx=0, fetch_idx=0.
- Reset mid-frame aborts immediately: line returns high and any partial word is discarded.
- TX FSM: IDLE, START, DATA, [PARITY], STOP.
  - IDLE with tx_start=1 at edge T: latch tx_data_in into a shift register and go to START.
  - tx_channel_out is 0 during cycle T+1.
  - DATA drives bit send_idx for send_idx = 0..BIT_LEN-1, one per cycle.
  - STOP drives 1 for one cycle, then IDLE.
  - tx_start is ignored outside IDLE.
  - tx_data_in is don't-care after latch.
  - Back-to-back: tx_start high in the first IDLE cycle starts the next frame, so the minimum gap is one idle-high cycle.
- TX state encoding: IDLE=0 and every other state nonzero, so "state != 0" means busy.
- RX FSM: IDLE, DATA, [PARITY], STOP.
  - IDLE: sampling rx_channel_in=0 moves to DATA with fetch_idx=0 and clears rx_out_vaild.
  - DATA: each cycle shifts the sampled bit into position fetch_idx. After BIT_LEN samples, go to [PARITY] then STOP.
  - STOP: the sampled bit must be 1.
  - Good frame: load rx_data_out with the assembled word and set rx_out_vaild=1 at that edge.
  - Bad frame (stop=0 or parity mismatch): rx_data_out is unchanged, rx_out_vaild stays 0.
  - Either case returns to IDLE.
- rx_out_vaild holds high until the next start bit or reset.
- Latency: tx_start edge to receiver rx_out_vaild is BIT_LEN+3 cycles (BIT_LEN+4 with PARITY_EN).
- RX state encoding: IDLE=0, so "state != 0" means a frame is in progress.
- Line held permanently low: each frame fails at STOP. RX returns to IDLE, then re-triggers on the next 0.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - TX inserts an even-parity bit (XOR of the data bits) between DATA and STOP.
  - RX checks it; a mismatch discards the frame as in the bad-frame case.
  - Frame length is BIT_LEN+3.
- Undefined: no parity state exists; frame length is BIT_LEN+2.

Decomposition:
- Shared package uart_pkg:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - rx_state_t enum (IDLE, DATA, PARITY, STOP).
  - Localparams LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
- Sub-modules:
  - uart_serial_tx (instance name tx), exposing internal state and send_idx.
  - uart_serial_rx (instance name rx), exposing state, fetch_idx and is_valid, where is_valid drives rx_out_vaild.
  - Top is wiring only.

Test Plan:
- Reset, no start (line held high) -> tx_channel_out=1, rx_out_vaild=0, both FSMs IDLE for 20 cycles.
- Two cross-connected instances, BIT_LEN=7; u0 sends 7'h55 with a one-cycle tx_start:
  - line must carry 0,1,0,1,0,1,0,1,1.
  - u1 reports rx_data_out=7'h55 and rx_out_vaild=1 at cycle T+10.
- Three back-to-back words 7'h7F, 7'h00, 7'h2A, each started when both FSMs are IDLE -> each received exactly, with rx_out_vaild dropping at each new start bit.
- rx_channel_in forced to 0 during the stop bit -> rx_data_out keeps its previous value, rx_out_vaild=0, RX returns to IDLE.
- rst asserted mid-DATA (send_idx=3) -> asynchronously, line=1, FSMs IDLE, rx_out_vaild=0. A subsequent 7'h33 transfer succeeds.
- With UART_PARITY_EN: 7'h07 sends parity bit 1; flipping the parity bit on the line -> word rejected, rx_out_vaild=0.
